// File: rtl/cpu_params_pkg.sv
// Core-wide architectural parameters shared by the CSR and trap blocks.
package cpu_params_pkg;
  localparam int unsigned RSZ = 32;
endpackage

// File: rtl/irq_arb_if.sv
// Trap request/acknowledge channel between the interrupt arbiter and the pipeline.
interface irq_arb_if #(
  parameter int unsigned NUM_EXT = 4
);
  localparam int unsigned IDW = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;

  logic                            irq_req;
  logic [cpu_params_pkg::RSZ-1:0]  irq_cause;
  logic [IDW-1:0]                  ext_id;
  logic                            irq_ack;
  logic                            mret;

  modport master (output irq_req, output irq_cause, output ext_id,
                  input  irq_ack, input  mret);
  modport slave  (input  irq_req, input  irq_cause, input  ext_id,
                  output irq_ack, output mret);
endinterface

// File: rtl/irq_arb.sv
// Machine-mode interrupt arbiter: synchronizes and ranks MEI/MSI/MTI, drives MIP,
// and issues one frozen trap request per interrupt, re-armed only by mret.
module irq_arb
  import cpu_params_pkg::*;
#(
  parameter int unsigned NUM_EXT     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               timer_irq,
  input  logic               sw_irq,
  input  logic [RSZ-1:0]     mie,
  input  logic               mstatus_mie,
  output logic [RSZ-1:0]     mip,
  irq_arb_if.master          bus
);

  localparam int unsigned IDW = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RET} state_t;

  state_t               state_q, state_d;
  logic [NUM_EXT-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_EXT-1:0]   ext_sync;
  logic [NUM_EXT-1:0]   ext_q;
  logic [RSZ-1:0]       mip_d;
  logic                 pend_ei, pend_si, pend_ti;
  logic [3:0]           code;
  logic [IDW-1:0]       cand_id;
  logic                 req_q, req_d;
  logic [RSZ-1:0]       cause_q, cause_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 unused_mie;

  // Only the machine-level enable bits participate in arbitration.
  assign unused_mie = ^{mie[RSZ-1:12], mie[10:8], mie[6:4], mie[2:0]};

  // Multi-flop synchronizer for the asynchronous external lines.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_irq;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ext_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    mip_d     = '0;
    mip_d[11] = |ext_sync;
    mip_d[7]  = timer_irq;
    mip_d[3]  = sw_irq;
  end

  // ext_q is kept cycle-aligned with mip so MEIP and the winning line id agree.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mip   <= '0;
      ext_q <= '0;
    end else begin
      mip   <= mip_d;
      ext_q <= ext_sync;
    end
  end

  // Fixed priority MEI > MSI > MTI; lowest external index wins.
  always_comb begin
    pend_ei = mip[11] & mie[11];
    pend_si = mip[3]  & mie[3];
    pend_ti = mip[7]  & mie[7];
    if (pend_ei)      code = 4'd11;
    else if (pend_si) code = 4'd3;
    else              code = 4'd7;
    cand_id = '0;
    for (int i = int'(NUM_EXT) - 1; i >= 0; i--) begin
      if (ext_q[i]) cand_id = IDW'(i);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cause_d = cause_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (mstatus_mie && (pend_ei || pend_si || pend_ti)) begin
          state_d = REQ;
          req_d   = 1'b1;
          cause_d = {1'b1, (RSZ-5)'(0), code};
          id_d    = cand_id;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (bus.irq_ack) begin
          state_d = WAIT_RET;
          req_d   = 1'b0;
        end
      end
      WAIT_RET: begin
        req_d = 1'b0;
        if (bus.mret) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cause_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cause_q <= cause_d;
      id_q    <= id_d;
    end
  end

  assign bus.irq_req   = req_q;
  assign bus.irq_cause = cause_q;
  assign bus.ext_id    = id_q;

endmodule
